traffic_light_module: RTL and testbench
=======================================

Name: traffic_light_module

Overview:
- Three-phase traffic-light sequencer: RED -> GREEN -> YELLOW -> RED, repeating.
- Each phase lasts a parameterised number of enabled clock cycles.
- The `enable` input gates progress; when low, the light freezes in its current phase with its elapsed time held.
- Leaf block driving lamp outputs directly; one-hot outputs, no handshake.

Parameters:
- RED_CYCLES, 8, enabled cycles spent in RED (must be >= 1)
- GREEN_CYCLES, 6, enabled cycles spent in GREEN (must be >= 1)
- YELLOW_CYCLES, 2, enabled cycles spent in YELLOW (must be >= 1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous reset, active-high (1 = reset asserted), despite the suffix
- enable  input  1  1 = phase timer advances this cycle; 0 = hold phase and timer
- red  output  1  high while in RED phase
- yellow  output  1  high while in YELLOW phase
- green  output  1  high while in GREEN phase

Behaviour:
- One clock, one asynchronous active-high reset. No other clock or reset domains.
- State: phase register with encodings RED, GREEN, YELLOW, plus a cycle counter.
  - Counter width = ceil(log2(max(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES))), minimum 1 bit.
- Reset (reset_n=1, asynchronous assert, released synchronously to clk by the system):
  - phase = RED, counter = 0.
  - Outputs immediately red=1, yellow=0, green=0, held for the whole reset duration.
  - Reset asserted mid-phase aborts that phase at once with no waiting for a clock edge.
- Outputs decoded combinationally from the phase register only (Moore).
  - Exactly one of red/yellow/green is 1 at all times, including during reset.
  - Never zero-hot, never multi-hot.
- Each rising edge with reset deasserted:
  - enable=0: phase and counter unchanged.
  - enable=1 and counter < DUR(phase)-1: counter += 1, phase unchanged.
  - enable=1 and counter == DUR(phase)-1: counter = 0, phase advances (RED->GREEN, GREEN->YELLOW, YELLOW->RED).
- Phase timing: each phase is visible for exactly DUR(phase) rising edges on which enable=1.
  - Disabled cycles inside a phase extend it without resetting its elapsed count.
- DUR=1 boundary: phase lasts exactly one enabled edge; counter stays 0.
- Enable toggled on the same edge as the terminal count: the sampled value decides. 1 advances, 0 holds at terminal count, so the next enabled edge advances.
- Illegal phase encoding (e.g. SEU): the next edge forces phase=RED, counter=0, regardless of enable. During that cycle the outputs still show red=1 (decode default).
- No wrap of counter beyond DUR-1. Counter never exceeds the current phase's DUR-1.
- First full cycle of the sequence = RED_CYCLES+GREEN_CYCLES+YELLOW_CYCLES enabled edges, then repeats identically.

Test Plan:
- Reset: assert reset_n=1 mid-GREEN between edges -> red=1, yellow=0, green=0 immediately. Stays RED while asserted, even with enable=1.
- Full sequence with defaults, enable=1 continuously after release -> red for 8 edges, green for 6, yellow for 2, red again at edge 16. Each output one-hot checked every cycle.
- Pause: enable=1 for 3 edges in RED, enable=0 for 10 edges, enable=1 again -> red held throughout the pause. Green appears after exactly 5 further enabled edges.
- Enable glitch: enable=1 for a single edge inside YELLOW (counter 0->1), then 0 -> still yellow. The next enabled edge moves to RED.
- Boundary params RED_CYCLES=GREEN_CYCLES=YELLOW_CYCLES=1, enable=1 -> phase changes on every edge: RED, GREEN, YELLOW, RED...
- Long run: random enable pattern for 2000 cycles -> one-hot invariant holds. Each phase's enabled-edge count equals its parameter, compared against a scoreboard model.

Source files
------------

// File: rtl/traffic_light_module.sv
// Three-phase traffic-light sequencer (RED -> GREEN -> YELLOW -> RED).
// Phase durations count enabled clock edges; lamps are a Moore decode of the phase register.
module traffic_light_module #(
    parameter int RED_CYCLES    = 8,
    parameter int GREEN_CYCLES  = 6,
    parameter int YELLOW_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic red,
    output logic yellow,
    output logic green
);

    localparam int MAX_RG     = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
    localparam int MAX_CYCLES = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_t;

    phase_t           r_phase;
    phase_t           w_phase_nxt;
    phase_t           w_phase_succ;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_last;
    logic             w_illegal;

    // Phase and elapsed-count registers; the reset input is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_phase <= PH_RED;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: hold when disabled, advance on terminal count, recover from bad encodings.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_cnt_nxt    = r_cnt;
        w_last       = RED_LAST;
        w_phase_succ = PH_GREEN;
        w_illegal    = 1'b0;
        case (r_phase)
            PH_RED: begin
                w_last       = RED_LAST;
                w_phase_succ = PH_GREEN;
            end
            PH_GREEN: begin
                w_last       = GREEN_LAST;
                w_phase_succ = PH_YELLOW;
            end
            PH_YELLOW: begin
                w_last       = YELLOW_LAST;
                w_phase_succ = PH_RED;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // >= also pulls an upset counter back to a legal value on the next enabled edge
        if (w_illegal) begin
            w_phase_nxt = PH_RED;
            w_cnt_nxt   = CNT_ZERO;
        end else if (enable) begin
            if (r_cnt >= w_last) begin
                w_phase_nxt = w_phase_succ;
                w_cnt_nxt   = CNT_ZERO;
            end else begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end
        end else begin
            w_phase_nxt = r_phase;
            w_cnt_nxt   = r_cnt;
        end
    end

    // Lamp decode; any unrecognised phase shows red so the outputs are never zero-hot.
    always_comb begin
        red    = 1'b1;
        yellow = 1'b0;
        green  = 1'b0;
        case (r_phase)
            PH_RED: begin
                red    = 1'b1;
                yellow = 1'b0;
                green  = 1'b0;
            end
            PH_GREEN: begin
                red    = 1'b0;
                yellow = 1'b0;
                green  = 1'b1;
            end
            PH_YELLOW: begin
                red    = 1'b0;
                yellow = 1'b1;
                green  = 1'b0;
            end
            default: begin
                red    = 1'b1;
                yellow = 1'b0;
                green  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_module.sv
// Bench for traffic_light_module: default-timing and all-ones-timing instances share stimulus;
// expected lamps come from the cumulative enabled-edge count modulo the full cycle length.
module tb_traffic_light_module;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic red_a, yellow_a, green_a;
    logic red_b, yellow_b, green_b;

    always #5 clk = ~clk;

    traffic_light_module #(
        .RED_CYCLES   (8),
        .GREEN_CYCLES (6),
        .YELLOW_CYCLES(2)
    ) u_dut_a (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .red    (red_a),
        .yellow (yellow_a),
        .green  (green_a)
    );

    traffic_light_module #(
        .RED_CYCLES   (1),
        .GREEN_CYCLES (1),
        .YELLOW_CYCLES(1)
    ) u_dut_b (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .red    (red_b),
        .yellow (yellow_b),
        .green  (green_b)
    );

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;
    int   tot_a  = 0;
    int   tot_b  = 0;

    // Expected {red,yellow,green} after tot enabled edges since reset.
    function automatic logic [2:0] exp_lamps(input int tot, input int r, input int g, input int y);
        int pos;
        pos = tot % (r + g + y);
        if (pos < r)          return 3'b100;
        else if (pos < r + g) return 3'b001;
        else                  return 3'b010;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.a = exp_lamps(tot_a, 8, 6, 2);
        e.b = exp_lamps(tot_b, 1, 1, 1);
        sb_q.push_back(e);
        -> sample_ev;
    endtask

    task automatic step(input logic en, input logic rst);
        @(negedge clk);
        enable  = en;
        reset_n = rst;
        @(posedge clk);
        if (rst) begin
            tot_a = 0;
            tot_b = 0;
        end else if (en) begin
            tot_a++;
            tot_b++;
        end
        #1;
        push_expected();
    endtask

    // Monitor: drains the scoreboard and compares against the lamps currently shown.
    initial begin
        exp_t       e;
        logic [2:0] act_a;
        logic [2:0] act_b;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e     = sb_q.pop_front();
                act_a = {red_a, yellow_a, green_a};
                act_b = {red_b, yellow_b, green_b};
                checks++;
                if (act_a !== e.a) begin
                    errors++;
                    $display("FAIL lamps_a t=%0t: got %b expected %b", $time, act_a, e.a);
                end
                checks++;
                if (!$onehot(act_a)) begin
                    errors++;
                    $display("FAIL onehot_a t=%0t: got %b expected one-hot", $time, act_a);
                end
                checks++;
                if (act_b !== e.b) begin
                    errors++;
                    $display("FAIL lamps_b t=%0t: got %b expected %b", $time, act_b, e.b);
                end
                checks++;
                if (!$onehot(act_b)) begin
                    errors++;
                    $display("FAIL onehot_b t=%0t: got %b expected one-hot", $time, act_b);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        #2;
        push_expected();
        repeat (3) step(1'b1, 1'b1);

        // two full sequences with enable held high
        repeat (34) step(1'b1, 1'b0);

        // async reset mid-GREEN, between edges, then held with enable high
        repeat (2) step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        #2;
        reset_n = 1'b1;
        tot_a   = 0;
        tot_b   = 0;
        #1;
        push_expected();
        repeat (4) step(1'b1, 1'b1);

        // pause inside RED
        repeat (3) step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0);

        // single-edge enable glitch inside YELLOW
        repeat (2) step(1'b0, 1'b1);
        repeat (14) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0);

        // long random run
        repeat (2000) step(1'($urandom_range(0, 1)), 1'b0);

        @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
